// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one access per MEM instruction over a doubleword req/ack bus,
// stalling the pipeline until completion and returning aligned, extended load data.
module mem_access_unit #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic              mem_err,
   output logic [DATA_W-1:0] mem_data,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [7:0]        bus_wmask,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic [1:0]        debug_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   state_t            state;
   logic [2:0]        off;
   logic [2:0]        off_q;
   logic [2:0]        funct3_q;
   logic [2:0]        align_mask;
   logic [7:0]        size_mask;
   logic              bad;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] load_ext;

   always_comb begin
      off = addr[2:0];
      case (funct3[1:0])
         2'b00:   begin align_mask = 3'b000; size_mask = 8'h01; end
         2'b01:   begin align_mask = 3'b001; size_mask = 8'h03; end
         2'b10:   begin align_mask = 3'b011; size_mask = 8'h0F; end
         default: begin align_mask = 3'b111; size_mask = 8'hFF; end
      endcase
      // Unsigned sizes (1xx) have no store form; 111 is never legal.
      bad = (funct3 == 3'b111) | (req_we & funct3[2]) | ((off & align_mask) != 3'b000);
   end

   assign mem_err     = (state == IDLE) & req_valid & bad;
   assign stall       = ((state == IDLE) & req_valid & ~bad) | (state == WAIT);
   assign debug_state = state;

   always_comb begin
      shifted = bus_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
         3'b010:  load_ext = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
         3'b100:  load_ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
         3'b101:  load_ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
         3'b110:  load_ext = {{(DATA_W-32){1'b0}}, shifted[31:0]};
         default: load_ext = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wmask <= 8'h00;
         mem_data  <= '0;
         off_q     <= 3'b000;
         funct3_q  <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && !bad) begin
                  bus_addr  <= {addr[ADDR_W-1:3], 3'b000};
                  bus_we    <= req_we;
                  bus_wdata <= wdata << {off, 3'b000};
                  bus_wmask <= req_we ? (size_mask << off) : 8'h00;
                  off_q     <= off;
                  funct3_q  <= funct3;
                  bus_req   <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               // All bus outputs hold until the ack; only then is the request dropped.
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (!bus_we) mem_data <= load_ext;
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: the driver pushes expected bus requests and
// load results; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic        stall;
   logic        mem_err;
   logic [63:0] mem_data;
   logic        bus_req;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic        bus_ack = 1'b0;
   logic [63:0] bus_rdata = '0;
   logic [1:0]  debug_state;

   int checks = 0;
   int failures = 0;

   // {bus_addr, bus_we, bus_wdata, bus_wmask}
   logic [136:0] bus_exp_q[$];
   logic [63:0]  exp_q[$];
   logic [63:0]  model_md = '0;
   logic         pending = 1'b0;

   mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .stall(stall), .mem_err(mem_err), .mem_data(mem_data),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wmask(bus_wmask), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .debug_state(debug_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // Reference: pick the addressed bytes out of the doubleword, then extend by signedness.
   function automatic logic [63:0] ref_load(input logic [63:0] rd, input int off, input logic [2:0] f3);
      int n;
      logic [63:0] v;
      logic [63:0] mask;
      n = 1 << f3[1:0];
      v = rd >> (8 * off);
      if (n == 8) return v;
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] rd, input int waits);
      int n;
      int off;
      logic bad;
      logic [7:0] wm;
      n = 1 << f3[1:0];
      off = int'(a % 8);
      bad = (f3 == 3'b111) || (we && f3[2]) || ((a % n) != 0);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
      bus_ack = 1'b0; bus_rdata = rnd64();
      @(negedge clk);
      chk("mem_err_req", mem_err, bad);
      chk("stall_req", stall, !bad);
      if (bad) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         @(negedge clk);
         chk("bus_req_after_bad", bus_req, 1'b0);
         chk("mem_data_after_bad", mem_data, model_md);
      end else begin
         wm = we ? 8'((((1 << n) - 1) << off) & 255) : 8'h00;
         bus_exp_q.push_back({a & ~64'h7, we, wd << (8 * off), wm});
         if (!we) model_md = ref_load(rd, off, f3);
         exp_q.push_back(model_md);
         for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            bus_ack = (k == waits);
            bus_rdata = (k == waits) ? rd : rnd64();
            @(negedge clk);
            chk("stall_wait", stall, 1'b1);
            chk("bus_req_wait", bus_req, 1'b1);
         end
         @(posedge clk); #1;
         bus_ack = 1'($urandom_range(0, 1));
         bus_rdata = rnd64();
         @(negedge clk);
         chk("stall_done", stall, 1'b0);
         chk("mem_err_done", mem_err, 1'b0);
         chk("bus_req_done", bus_req, 1'b0);
      end
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         bus_ack = 1'($urandom_range(0, 1));
         bus_rdata = rnd64();
         @(negedge clk);
         chk("bus_req_idle", bus_req, 1'b0);
         chk("stall_idle", stall, 1'b0);
         chk("mem_data_idle", mem_data, model_md);
      end
   endtask

   task automatic reset_in_wait();
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b011; addr = 64'h3000; wdata = rnd64();
      bus_ack = 1'b0;
      bus_exp_q.push_back({64'h3000, 1'b0, addr == 64'h3000 ? wdata : 64'h0, 8'h00});
      @(negedge clk);
      chk("stall_rst_req", stall, 1'b1);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      chk("bus_req_rst_wait", bus_req, 1'b1);
      @(posedge clk); #1;
      rstn = 1'b0; req_valid = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1; bus_ack = 1'b1; bus_rdata = rnd64();
      bus_exp_q.delete();
      model_md = '0;
      @(negedge clk);
      chk("bus_req_after_rst", bus_req, 1'b0);
      chk("stall_after_rst", stall, 1'b0);
      chk("mem_data_after_rst", mem_data, 64'h0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      chk("bus_req_late_ack", bus_req, 1'b0);
      chk("mem_data_late_ack", mem_data, 64'h0);
   endtask

   initial begin : monitor
      logic [136:0] got;
      forever begin
         @(negedge clk);
         if (pending) begin
            pending = 1'b0;
            if (exp_q.size() == 0) chk("mem_data_unexpected", 1'b1, 1'b0);
            else chk("mem_data", mem_data, exp_q.pop_front());
         end
         if (rstn && bus_req) begin
            got = {bus_addr, bus_we, bus_wdata, bus_wmask};
            if (bus_exp_q.size() == 0) begin
               chk("bus_req_unexpected", bus_req, 1'b0);
            end else begin
               chk("bus_fields", got, bus_exp_q[0]);
               if (bus_ack) begin
                  void'(bus_exp_q.pop_front());
                  pending = 1'b1;
               end
            end
         end
      end
   end

   initial begin : driver
      int f3;
      int n;
      int off;
      logic we;
      logic [63:0] a;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_addr", bus_addr, 64'h0);
      chk("rst_bus_wdata", bus_wdata, 64'h0);
      chk("rst_bus_wmask", bus_wmask, 8'h00);
      chk("rst_mem_data", mem_data, 64'h0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_mem_err", mem_err, 1'b0);
      @(posedge clk); #1;
      rstn = 1'b1;

      do_req(1'b0, 3'b011, 64'h1000, rnd64(), 64'h0123456789ABCDEF, 0);
      idle(1);
      do_req(1'b0, 3'b000, 64'h1003, rnd64(), 64'h0000000080000000, 3);
      do_req(1'b0, 3'b101, 64'h2006, rnd64(), 64'hBEEF000000000000, 1);
      idle(1);
      do_req(1'b1, 3'b010, 64'h1004, 64'h1122334455667788, rnd64(), 2);
      do_req(1'b0, 3'b010, 64'h1002, rnd64(), rnd64(), 0);
      do_req(1'b0, 3'b111, 64'h1000, rnd64(), rnd64(), 0);
      do_req(1'b1, 3'b100, 64'h1000, rnd64(), rnd64(), 0);
      idle(1);
      reset_in_wait();
      do_req(1'b0, 3'b011, 64'h1000, rnd64(), 64'hFEDCBA9876543210, 0);
      idle(2);

      for (int t = 0; t < 60; t++) begin
         f3 = $urandom_range(0, 7);
         we = 1'($urandom_range(0, 1));
         n = 1 << f3[1:0];
         off = $urandom_range(0, 7);
         if ($urandom_range(0, 3) != 0) off = off & ~(n - 1);
         a = (rnd64() & ~64'h7) | 64'(off);
         do_req(we, 3'(f3), a, rnd64(), rnd64(), $urandom_range(0, 3));
         idle($urandom_range(0, 2));
      end

      idle(2);
      chk("bus_queue_drained", 137'(bus_exp_q.size()), 137'd0);
      chk("data_queue_drained", 137'(exp_q.size()), 137'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
